// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one tile-map RAM port between the display fetch and a writer.
// Define VRAM_ARB_BLANK_WR_EN to grant writes only during vertical blanking (pixel_y >= 480).
module vram_arbiter #(
    parameter int DW        = 4,
    parameter int MAP_WORDS = 1200
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p_tick,
    input  logic [9:0]    pixel_x,
    input  logic [9:0]    pixel_y,
    input  logic          wr_req,
    input  logic [10:0]   wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic [10:0]   ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] tile_code,
    output logic          tile_valid
);
    typedef enum logic {IDLE, WACK} state_t;
    state_t state_q, state_d;
    logic [9:0] nxt_y;
    logic [5:0] col;
    logic [4:0] row;
    logic [10:0] slot_addr;
    logic line_end, exists, slot, load, grant, wr_go;
    logic slot_q, next_valid_q, tile_valid_q;
    logic [DW-1:0] next_tile_q, tile_code_q;

    // Fetch the tile one column ahead; at pixel_x=798 prefetch column 0 of the next line.
    always_comb begin
        nxt_y     = (pixel_y == 10'd524) ? 10'd0 : pixel_y + 10'd1;
        line_end  = pixel_x == 10'd798;
        col       = line_end ? 6'd0 : pixel_x[9:4] + 6'd1;
        row       = line_end ? nxt_y[8:4] : pixel_y[8:4];
        exists    = line_end ? (nxt_y < 10'd480) : (pixel_x < 10'd638 && pixel_y < 10'd480);
        slot      = p_tick && pixel_x[3:0] == 4'd14 && exists;
        load      = p_tick && pixel_x[3:0] == 4'd15;
        slot_addr = {1'b0, row, 5'b0} + {3'b0, row, 3'b0} + {5'b0, col};
    end

`ifdef VRAM_ARB_BLANK_WR_EN
    assign grant = !slot && pixel_y >= 10'd480;
`else
    assign grant = !slot;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE && wr_req && grant) ? WACK : IDLE;
    end

    always_comb begin
        wr_go     = state_q == IDLE && wr_req && grant;
        wr_ack    = state_q == WACK;
        ram_addr  = slot ? slot_addr : wr_go ? wr_addr : 11'd0;
        ram_we    = wr_go && wr_addr < 11'(MAP_WORDS);
        ram_wdata = wr_go ? wr_data : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q       <= 1'b0;
            next_tile_q  <= '0;
            next_valid_q <= 1'b0;
            tile_code_q  <= '0;
            tile_valid_q <= 1'b0;
        end else begin
            slot_q <= slot;
            if (slot_q) next_tile_q <= ram_rdata;
            next_valid_q <= slot_q ? 1'b1 : load ? 1'b0 : next_valid_q;
            if (load) begin
                tile_code_q  <= next_tile_q;
                tile_valid_q <= next_valid_q;
            end
        end
    end

    assign tile_code  = tile_code_q;
    assign tile_valid = tile_valid_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed vector table plus multi-cycle sequences against a RAM model.
module tb_vram_arbiter;
    localparam int DW = 4;
    logic clk = 1'b0, reset = 1'b1, p_tick = 1'b0, wr_req = 1'b0;
    logic [9:0] pixel_x = '0, pixel_y = '0;
    logic [10:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic wr_ack, ram_we, tile_valid;
    logic [10:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata, tile_code;
    logic [DW-1:0] mem [2048];
    int checks = 0, fails = 0;

    typedef struct {int pt, x, y, req, wa, wd, ea, ewe, ewd, eack;} vec_t;
    vec_t vt [16];

    always #5 clk = ~clk;

    vram_arbiter #(.DW(DW), .MAP_WORDS(1200)) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .tile_code(tile_code), .tile_valid(tile_valid)
    );

    // Synchronous-read RAM; reset reloads map word 41 with 4'hA, everything else 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2048; i++) mem[i] <= (i == 41) ? 4'hA : 4'h0;
            ram_rdata <= '0;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic drive(input int pt, input int x, input int y, input int req, input int wa, input int wd);
        @(posedge clk);
        #1;
        p_tick = 1'(pt); pixel_x = 10'(x); pixel_y = 10'(y);
        wr_req = 1'(req); wr_addr = 11'(wa); wr_data = 4'(wd);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1; wr_req = 1'b0; p_tick = 1'b0; pixel_x = '0; pixel_y = '0;
        #1;
        chk("rst wr_ack", 32'(wr_ack), 0);
        chk("rst tile_valid", 32'(tile_valid), 0);
        chk("rst tile_code", 32'(tile_code), 0);
        chk("rst ram_we", 32'(ram_we), 0);
        chk("rst ram_addr", 32'(ram_addr), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int we_n, ack_n, req_on, ack_at;
        vt[0]  = '{1, 14, 16, 0, 0, 0, 41, 0, 0, 0};
        vt[1]  = '{1, 638, 16, 0, 0, 0, 0, 0, 0, 0};
        vt[2]  = '{1, 622, 0, 0, 0, 0, 39, 0, 0, 0};
        vt[3]  = '{1, 622, 479, 0, 0, 0, 1199, 0, 0, 0};
        vt[4]  = '{1, 14, 480, 0, 0, 0, 0, 0, 0, 0};
        vt[5]  = '{1, 798, 479, 0, 0, 0, 0, 0, 0, 0};
        vt[6]  = '{1, 798, 524, 1, 7, 9, 0, 0, 0, 0};
        vt[7]  = '{1, 798, 100, 0, 0, 0, 240, 0, 0, 0};
        vt[8]  = '{1, 670, 500, 1, 5, 3, 5, 1, 3, 0};
        vt[9]  = '{0, 671, 500, 1, 5, 3, 0, 0, 0, 1};
        vt[10] = '{0, 14, 16, 0, 0, 0, 0, 0, 0, 0};
        vt[11] = '{0, 14, 500, 1, 1200, 5, 1200, 0, 5, 0};
        vt[12] = '{0, 15, 500, 0, 0, 0, 0, 0, 0, 1};
        vt[13] = '{1, 15, 16, 0, 0, 0, 0, 0, 0, 0};
        vt[14] = '{1, 30, 29, 0, 0, 0, 42, 0, 0, 0};
        vt[15] = '{1, 798, 523, 0, 0, 0, 0, 0, 0, 0};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(vt[i].pt, vt[i].x, vt[i].y, vt[i].req, vt[i].wa, vt[i].wd);
            chk($sformatf("vec%0d ram_addr", i), 32'(ram_addr), 32'(vt[i].ea));
            chk($sformatf("vec%0d ram_we", i), 32'(ram_we), 32'(vt[i].ewe));
            chk($sformatf("vec%0d ram_wdata", i), 32'(ram_wdata), 32'(vt[i].ewd));
            chk($sformatf("vec%0d wr_ack", i), 32'(wr_ack), 32'(vt[i].eack));
        end

        // Tile fetch: slot at x=14 reads word 41, tile visible from x=16.
        do_reset();
        for (int x = 0; x <= 17; x++) begin
            drive(0, x, 16, 0, 0, 0);
            if (x == 16) begin
                chk("fetch tile_code", 32'(tile_code), 32'hA);
                chk("fetch tile_valid", 32'(tile_valid), 1);
            end
            drive(1, x, 16, 0, 0, 0);
            if (x == 14) chk("fetch ram_addr", 32'(ram_addr), 41);
        end

        // Last visible line: no prefetch, so line 480 starts invalid.
        for (int x = 796; x <= 799; x++) begin
            drive(0, x, 479, 0, 0, 0);
            drive(1, x, 479, 0, 0, 0);
        end
        drive(0, 0, 480, 0, 0, 0);
        chk("line480 tile_valid", 32'(tile_valid), 0);

        // Frame wrap: y=524, x=798 prefetches word 0 for line 0.
        drive(0, 798, 524, 0, 0, 0);
        drive(1, 798, 524, 0, 0, 0);
        chk("wrap ram_addr", 32'(ram_addr), 0);
        drive(0, 799, 524, 0, 0, 0);
        drive(1, 799, 524, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("wrap tile_valid", 32'(tile_valid), 1);
        chk("wrap tile_code", 32'(tile_code), 0);

`ifndef VRAM_ARB_BLANK_WR_EN
        // Write raised in a slot waits exactly one cycle.
        drive(0, 14, 16, 0, 0, 0);
        drive(1, 14, 16, 1, 5, 3);
        chk("slotwr ram_addr", 32'(ram_addr), 41);
        chk("slotwr ram_we", 32'(ram_we), 0);
        drive(0, 15, 16, 1, 5, 3);
        chk("slotwr we", 32'(ram_we), 1);
        chk("slotwr addr", 32'(ram_addr), 5);
        chk("slotwr wdata", 32'(ram_wdata), 3);
        chk("slotwr early ack", 32'(wr_ack), 0);
        drive(1, 15, 16, 1, 5, 3);
        chk("slotwr ack", 32'(wr_ack), 1);
        chk("slotwr ack no we", 32'(ram_we), 0);
        drive(0, 16, 16, 0, 0, 0);
        chk("slotwr map5", 32'(mem[5]), 3);
`else
        // Blanking-only writes: pending through the active area, acked once y reaches 480.
        we_n = 0; ack_n = 0;
        for (int i = 0; i < 20; i++) begin
            drive(i % 2, i / 2, 100, 1, 9, 6);
            if (ram_we) we_n++;
            if (wr_ack) ack_n++;
        end
        chk("blank no ack", 32'(ack_n), 0);
        chk("blank no we", 32'(we_n), 0);
        ack_at = 0; req_on = 1;
        for (int i = 1; i <= 4; i++) begin
            drive(i % 2, 700, 480, req_on, 9, 6);
            if (wr_ack && ack_at == 0) begin ack_at = i; req_on = 0; end
        end
        chk("blank ack cycle", 32'(ack_at), 2);
        chk("blank map9", 32'(mem[9]), 6);
`endif

        // Out-of-range write: acked once, never written.
        we_n = 0; ack_n = 0; req_on = 1;
        for (int i = 0; i < 6; i++) begin
            drive(i % 2, 700, 500, req_on, 1200, 7);
            if (ram_we) we_n++;
            if (wr_ack) begin ack_n++; req_on = 0; end
        end
        chk("oor ack count", 32'(ack_n), 1);
        chk("oor we count", 32'(we_n), 0);

        // Reset in the write cycle abandons the write without an ack.
        drive(0, 700, 500, 1, 9, 2);
        chk("rstwr we", 32'(ram_we), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("rstwr async we", 32'(ram_we), 1);
        wr_req = 1'b0;
        @(posedge clk);
        #2;
        chk("rstwr no ack", 32'(wr_ack), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 14, 16, 0, 0, 0);
        chk("rstwr ack after", 32'(wr_ack), 0);
        drive(1, 14, 16, 0, 0, 0);
        chk("resume ram_addr", 32'(ram_addr), 41);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
